fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline. It owns the fetch PC and drives a single-outstanding request/response interface to instruction memory. It also holds the IF/ID pipeline register. It consumes StallF/StallD/FlushD and the branch redirect (PCSrcE/PCTargetE) from the hazard and execute logic, and produces InstrD/PCD/PCPlus4D for decode.

---
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with a single-outstanding instruction-memory port
// and the IF/ID pipeline register.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   StallF_i               suppress new fetch requests
//   StallD_i               hold the IF/ID register
//   FlushD_i               clear the IF/ID register to a bubble
//   PCSrcE_i, PCTargetE_i  taken-branch redirect from execute
//   ImemReq_o, ImemAddr_o  request strobe and address (= PCF)
//   ImemValid_i, ImemRdata_i  response strobe and instruction word
//   InstrD_o, PCD_o, PCPlus4D_o, ValidD_o  IF/ID register contents
//   PCF_o                  current fetch PC
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        StallF_i,
  input  logic        StallD_i,
  input  logic        FlushD_i,
  input  logic        PCSrcE_i,
  input  logic [31:0] PCTargetE_i,
  output logic        ImemReq_o,
  output logic [31:0] ImemAddr_o,
  input  logic        ImemValid_i,
  input  logic [31:0] ImemRdata_i,
  output logic [31:0] InstrD_o,
  output logic [31:0] PCD_o,
  output logic [31:0] PCPlus4D_o,
  output logic        ValidD_o,
  output logic [31:0] PCF_o
);

  typedef enum logic [1:0] {StIssue, StWait, StHold, StDiscard} state_t;

  state_t      state;
  logic [31:0] pcf;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  logic        req;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] deliver_pc;

  // A redirect in ISSUE cancels the request so the stale PC is never fetched.
  always_comb begin
    req           = !rst_i && (state == StIssue) && !StallF_i && !PCSrcE_i;
    deliver       = 1'b0;
    deliver_instr = ImemRdata_i;
    deliver_pc    = pcf;
    case (state)
      StWait: begin
        if (ImemValid_i && !PCSrcE_i && !StallD_i) deliver = 1'b1;
      end
      StHold: begin
        if (!PCSrcE_i && !StallD_i) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr;
          deliver_pc    = hold_pc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= StIssue;
      pcf        <= RESET_PC;
      hold_instr <= 32'd0;
      hold_pc    <= 32'd0;
      InstrD_o   <= NOP_INSTR;
      PCD_o      <= 32'd0;
      PCPlus4D_o <= 32'd0;
      ValidD_o   <= 1'b0;
    end else begin
      // Redirect always wins over sequential advance, in every state.
      if (PCSrcE_i) begin
        pcf <= PCTargetE_i;
      end else if (deliver) begin
        pcf <= pcf + 32'd4;
      end

      case (state)
        StIssue: begin
          if (req) state <= StWait;
        end
        StWait: begin
          if (ImemValid_i) begin
            if (PCSrcE_i) begin
              state <= StIssue;
            end else if (StallD_i) begin
              hold_instr <= ImemRdata_i;
              hold_pc    <= pcf;
              state      <= StHold;
            end else begin
              state <= StIssue;
            end
          end else if (PCSrcE_i) begin
            // Response still owed for the old PC; must drain it first.
            state <= StDiscard;
          end
        end
        StHold: begin
          if (PCSrcE_i || !StallD_i) state <= StIssue;
        end
        StDiscard: begin
          if (ImemValid_i) state <= StIssue;
        end
        default: state <= StIssue;
      endcase

      if (FlushD_i) begin
        InstrD_o   <= NOP_INSTR;
        PCD_o      <= 32'd0;
        PCPlus4D_o <= 32'd0;
        ValidD_o   <= 1'b0;
      end else if (StallD_i) begin
        // hold
      end else if (deliver) begin
        InstrD_o   <= deliver_instr;
        PCD_o      <= deliver_pc;
        PCPlus4D_o <= deliver_pc + 32'd4;
        ValidD_o   <= 1'b1;
      end else begin
        InstrD_o   <= NOP_INSTR;
        PCD_o      <= 32'd0;
        PCPlus4D_o <= 32'd0;
        ValidD_o   <= 1'b0;
      end
    end
  end

  assign ImemReq_o  = req;
  assign ImemAddr_o = pcf;
  assign PCF_o      = pcf;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage with a simple
// instruction-memory model that returns word = address after a programmable delay.
module tb_fetch_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f, stall_d, flush_d, pc_src;
  logic [31:0] pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d, pc_d, pc_plus4_d, pc_f;
  logic        valid_d;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model
  logic        mem_pending;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          mem_delay = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .StallF_i    (stall_f),
    .StallD_i    (stall_d),
    .FlushD_i    (flush_d),
    .PCSrcE_i    (pc_src),
    .PCTargetE_i (pc_target),
    .ImemReq_o   (imem_req),
    .ImemAddr_o  (imem_addr),
    .ImemValid_i (imem_valid),
    .ImemRdata_i (imem_rdata),
    .InstrD_o    (instr_d),
    .PCD_o       (pc_d),
    .PCPlus4D_o  (pc_plus4_d),
    .ValidD_o    (valid_d),
    .PCF_o       (pc_f)
  );

  assign imem_valid = mem_pending && (mem_cnt == 0);
  assign imem_rdata = mem_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_pending <= 1'b0;
      mem_addr    <= 32'd0;
      mem_cnt     <= 0;
    end else if (imem_req) begin
      mem_pending <= 1'b1;
      mem_addr    <= imem_addr;
      mem_cnt     <= mem_delay;
    end else if (imem_valid) begin
      mem_pending <= 1'b0;
    end else if (mem_pending && mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] pc4, input logic v);
    check({tag, ".instr"}, instr_d, instr);
    check({tag, ".pcd"}, pc_d, pc);
    check({tag, ".pc4"}, pc_plus4_d, pc4);
    check({tag, ".valid"}, {31'd0, valid_d}, {31'd0, v});
  endtask

  initial begin
    rst = 1'b1;
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pc_src = 1'b0; pc_target = 32'd0;
    #2;
    check("rst.req", {31'd0, imem_req}, 32'd0);
    check("rst.pcf", pc_f, 32'hBFC0_0000);
    chk_ifid("rst", Nop, 32'd0, 32'd0, 1'b0);

    // Zero-wait sequential fetch
    cyc(); rst = 1'b0; #1;                                   // C0
    check("c0.req", {31'd0, imem_req}, 32'd1);
    check("c0.addr", imem_addr, 32'hBFC0_0000);
    cyc(); #1;                                               // C1 WAIT
    check("c1.req", {31'd0, imem_req}, 32'd0);
    cyc(); #1;                                               // C2
    chk_ifid("c2", 32'hBFC0_0000, 32'hBFC0_0000, 32'hBFC0_0004, 1'b1);
    check("c2.req", {31'd0, imem_req}, 32'd1);
    check("c2.addr", imem_addr, 32'hBFC0_0004);
    cyc(); #1;                                               // C3
    check("c3.valid", {31'd0, valid_d}, 32'd0);
    check("c3.req", {31'd0, imem_req}, 32'd0);

    // StallD for 3 cycles across a response
    cyc(); stall_d = 1'b1; #1;                               // C4
    chk_ifid("c4", 32'hBFC0_0004, 32'hBFC0_0004, 32'hBFC0_0008, 1'b1);
    check("c4.addr", imem_addr, 32'hBFC0_0008);
    check("c4.req", {31'd0, imem_req}, 32'd1);
    cyc(); #1;                                               // C5 response arrives
    check("c5.mvalid", {31'd0, imem_valid}, 32'd1);
    chk_ifid("c5", 32'hBFC0_0004, 32'hBFC0_0004, 32'hBFC0_0008, 1'b1);
    cyc(); #1;                                               // C6 HOLD
    chk_ifid("c6", 32'hBFC0_0004, 32'hBFC0_0004, 32'hBFC0_0008, 1'b1);
    check("c6.req", {31'd0, imem_req}, 32'd0);
    cyc(); stall_d = 1'b0; #1;                               // C7 release
    check("c7.req", {31'd0, imem_req}, 32'd0);
    check("c7.pcf", pc_f, 32'hBFC0_0008);
    cyc(); mem_delay = 3; #1;                                // C8 buffered word delivered
    chk_ifid("c8", 32'hBFC0_0008, 32'hBFC0_0008, 32'hBFC0_000C, 1'b1);
    check("c8.addr", imem_addr, 32'hBFC0_000C);
    check("c8.req", {31'd0, imem_req}, 32'd1);

    // Redirect + flush while the response is delayed
    cyc(); mem_delay = 0; pc_src = 1'b1; pc_target = 32'h100; flush_d = 1'b1; #1;  // C9
    check("c9.valid", {31'd0, valid_d}, 32'd0);
    check("c9.req", {31'd0, imem_req}, 32'd0);
    cyc(); pc_src = 1'b0; flush_d = 1'b0; #1;                // C10 DISCARD
    check("c10.pcf", pc_f, 32'h100);
    check("c10.req", {31'd0, imem_req}, 32'd0);
    chk_ifid("c10", Nop, 32'd0, 32'd0, 1'b0);
    cyc(); #1;                                               // C11
    check("c11.req", {31'd0, imem_req}, 32'd0);
    cyc(); #1;                                               // C12 stale response
    check("c12.mvalid", {31'd0, imem_valid}, 32'd1);
    check("c12.req", {31'd0, imem_req}, 32'd0);
    cyc(); #1;                                               // C13
    check("c13.req", {31'd0, imem_req}, 32'd1);
    check("c13.addr", imem_addr, 32'h100);
    check("c13.valid", {31'd0, valid_d}, 32'd0);

    // Redirect coincident with response in WAIT
    cyc(); pc_src = 1'b1; pc_target = 32'h200; #1;           // C14
    check("c14.mvalid", {31'd0, imem_valid}, 32'd1);
    check("c14.req", {31'd0, imem_req}, 32'd0);

    // StallF for 2 cycles in ISSUE
    cyc(); pc_src = 1'b0; stall_f = 1'b1; #1;                // C15
    check("c15.valid", {31'd0, valid_d}, 32'd0);
    check("c15.req", {31'd0, imem_req}, 32'd0);
    check("c15.pcf", pc_f, 32'h200);
    cyc(); #1;                                               // C16
    check("c16.req", {31'd0, imem_req}, 32'd0);
    check("c16.pcf", pc_f, 32'h200);
    check("c16.valid", {31'd0, valid_d}, 32'd0);
    cyc(); stall_f = 1'b0; #1;                               // C17
    check("c17.req", {31'd0, imem_req}, 32'd1);
    check("c17.addr", imem_addr, 32'h200);
    cyc(); #1;                                               // C18 WAIT
    cyc(); #1;                                               // C19
    chk_ifid("c19", 32'h200, 32'h200, 32'h204, 1'b1);
    check("c19.pcf", pc_f, 32'h204);

    // PC wrap at FFFFFFFC
    pc_src = 1'b1; pc_target = 32'hFFFF_FFFC; #1;
    check("c19.req_redirect", {31'd0, imem_req}, 32'd0);
    cyc(); pc_src = 1'b0; #1;                                // C20
    check("c20.addr", imem_addr, 32'hFFFF_FFFC);
    check("c20.req", {31'd0, imem_req}, 32'd1);
    cyc(); #1;                                               // C21 WAIT
    cyc(); stall_d = 1'b1; #1;                               // C22
    chk_ifid("c22", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd0, 1'b1);
    check("c22.addr", imem_addr, 32'd0);
    check("c22.req", {31'd0, imem_req}, 32'd1);
    cyc(); #1;                                               // C23 WAIT, IF/ID held
    check("c23.pcf", pc_f, 32'd0);
    check("c23.valid", {31'd0, valid_d}, 32'd1);

    // Asynchronous reset mid-WAIT, away from any clock edge
    rst = 1'b1; #1;
    check("arst.pcf", pc_f, 32'hBFC0_0000);
    check("arst.req", {31'd0, imem_req}, 32'd0);
    chk_ifid("arst", Nop, 32'd0, 32'd0, 1'b0);
    cyc(); rst = 1'b0; stall_d = 1'b0; #1;
    check("post.req", {31'd0, imem_req}, 32'd1);
    check("post.addr", imem_addr, 32'hBFC0_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
